// File: rtl/sal_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sal_sched_pkg                                              |
// | Description : Shared types for the DRAM command scheduler. Defines the   |
// |               command encoding driven on the command bus and a helper    |
// |               that sizes bank-index fields.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sal_sched_pkg;

   // Command encoding presented to the DRAM command/address driver.
   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } sal_cmd_t;

   // Width of an index into N items; never below one bit.
   function automatic int unsigned sal_idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : sal_sched_pkg
`default_nettype wire

// File: rtl/sal_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sal_rr_arbiter                                             |
// | Description : One-hot arbiter over N requesters. POLICY=1 grants the     |
// |               first requester at or after ptr_i, wrapping N-1 -> 0.      |
// |               POLICY=0 ignores ptr_i and grants the lowest index.        |
// | Ports       : req_i  [N]  request vector                                 |
// |               ptr_i  [PW] round-robin start position                     |
// |               gnt_o  [N]  one-hot grant (all zero when no request)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sal_rr_arbiter
   import sal_sched_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned POLICY = 1,
   parameter int unsigned PW     = sal_idx_w(N)
)(
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic found;

   // First pass covers [ptr, N-1]; second pass wraps round to [0, ptr-1].
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req_i[i] && ((POLICY == 0) || (i >= 32'(ptr_i)))) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule : sal_rr_arbiter
`default_nettype wire

// File: rtl/sal_sched_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sal_sched_rr                                               |
// | Description : DRAM command scheduler for BK_CNT bank controllers. Picks  |
// |               at most one ACT/RD/WR/PRE/REF request per cycle by class   |
// |               (REF > starved > CAS same dir > CAS other dir > ACT > PRE), |
// |               issues a combinational one-hot grant and registers the     |
// |               granted command and its fields for the next cycle.         |
// | Ports       : clk, rst (sync, active-high), stall (no grant while high)  |
// |               *_req_arr  [BK_CNT]   per-bank level requests              |
// |               ra/ca/id/len_arr      per-bank packed fields               |
// |               *_gnt_arr  [BK_CNT]   one-hot grants, same cycle           |
// |               cmd_valid/cmd/cmd_ba/cmd_ra/ca/id/len  registered command  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sal_sched_rr
   import sal_sched_pkg::*;
#(
   parameter int unsigned BK_CNT     = 8,
   parameter int unsigned RA_W       = 14,
   parameter int unsigned CA_W       = 10,
   parameter int unsigned ID_W       = 4,
   parameter int unsigned LEN_W      = 4,
   parameter int unsigned POLICY     = 1,
   parameter int unsigned STARVE_LIM = 16
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic [BK_CNT-1:0]         act_req_arr,
   input  logic [BK_CNT-1:0]         rd_req_arr,
   input  logic [BK_CNT-1:0]         wr_req_arr,
   input  logic [BK_CNT-1:0]         pre_req_arr,
   input  logic [BK_CNT-1:0]         ref_req_arr,
   input  logic [BK_CNT*RA_W-1:0]    ra_arr,
   input  logic [BK_CNT*CA_W-1:0]    ca_arr,
   input  logic [BK_CNT*ID_W-1:0]    id_arr,
   input  logic [BK_CNT*LEN_W-1:0]   len_arr,
   output logic [BK_CNT-1:0]         act_gnt_arr,
   output logic [BK_CNT-1:0]         rd_gnt_arr,
   output logic [BK_CNT-1:0]         wr_gnt_arr,
   output logic [BK_CNT-1:0]         pre_gnt_arr,
   output logic [BK_CNT-1:0]         ref_gnt_arr,
   output logic                      cmd_valid,
   output sal_cmd_t                  cmd,
   output logic [$clog2(BK_CNT)-1:0] cmd_ba,
   output logic [RA_W-1:0]           cmd_ra,
   output logic [CA_W-1:0]           cmd_ca,
   output logic [ID_W-1:0]           cmd_id,
   output logic [LEN_W-1:0]          cmd_len
);

   localparam int unsigned BA_W  = $clog2(BK_CNT);
   localparam int unsigned AGE_W = $clog2(STARVE_LIM + 1);
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

   // Per-command round-robin pointers; RD and WR keep their own pointer so a
   // direction flip does not disturb the fairness history of either queue.
   logic [BA_W-1:0]  act_ptr_q, rd_ptr_q, wr_ptr_q, pre_ptr_q, ref_ptr_q;
   logic [BA_W-1:0]  act_ptr_d, rd_ptr_d, wr_ptr_d, pre_ptr_d, ref_ptr_d;
   logic             last_wr_q, last_wr_d;      // 0: last CAS was RD, 1: WR
   logic [AGE_W-1:0] age_q [BK_CNT];
   logic [AGE_W-1:0] age_d [BK_CNT];

   logic [BK_CNT-1:0] any_req, starved, cas_same, cas_oth;
   logic [BA_W-1:0]   same_ptr, oth_ptr, ptr_nxt;
   logic [BK_CNT-1:0] arb_ref, arb_stv, arb_same, arb_oth, arb_act, arb_pre;
   logic [BK_CNT-1:0] win_vec;
   logic [BA_W-1:0]   win_idx;
   sal_cmd_t          win_cmd;

   logic              cmd_valid_q, cmd_valid_d;
   sal_cmd_t          cmd_q, cmd_d;
   logic [BA_W-1:0]   cmd_ba_q, cmd_ba_d;
   logic [RA_W-1:0]   cmd_ra_q, cmd_ra_d;
   logic [CA_W-1:0]   cmd_ca_q, cmd_ca_d;
   logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
   logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

   assign any_req = act_req_arr | rd_req_arr | wr_req_arr | pre_req_arr | ref_req_arr;

   for (genvar b = 0; b < BK_CNT; b++) begin : g_starve
      assign starved[b] = any_req[b] && (age_q[b] >= AGE_LIM);
   end

   assign cas_same = last_wr_q ? wr_req_arr : rd_req_arr;
   assign cas_oth  = last_wr_q ? rd_req_arr : wr_req_arr;
   assign same_ptr = last_wr_q ? wr_ptr_q   : rd_ptr_q;
   assign oth_ptr  = last_wr_q ? rd_ptr_q   : wr_ptr_q;

   sal_rr_arbiter #(.N(BK_CNT), .POLICY(POLICY)) u_arb_ref
      (.req_i(ref_req_arr), .ptr_i(ref_ptr_q), .gnt_o(arb_ref));
   // Starved banks are always resolved lowest-index first.
   sal_rr_arbiter #(.N(BK_CNT), .POLICY(0)) u_arb_stv
      (.req_i(starved), .ptr_i('0), .gnt_o(arb_stv));
   sal_rr_arbiter #(.N(BK_CNT), .POLICY(POLICY)) u_arb_same
      (.req_i(cas_same), .ptr_i(same_ptr), .gnt_o(arb_same));
   sal_rr_arbiter #(.N(BK_CNT), .POLICY(POLICY)) u_arb_oth
      (.req_i(cas_oth), .ptr_i(oth_ptr), .gnt_o(arb_oth));
   sal_rr_arbiter #(.N(BK_CNT), .POLICY(POLICY)) u_arb_act
      (.req_i(act_req_arr), .ptr_i(act_ptr_q), .gnt_o(arb_act));
   sal_rr_arbiter #(.N(BK_CNT), .POLICY(POLICY)) u_arb_pre
      (.req_i(pre_req_arr), .ptr_i(pre_ptr_q), .gnt_o(arb_pre));

   // Class select: the winning bank's own request type becomes the grant.
   always_comb begin
      win_vec = '0;
      if (!rst && !stall) begin
         if      (|ref_req_arr) win_vec = arb_ref;
         else if (|starved)     win_vec = arb_stv;
         else if (|cas_same)    win_vec = arb_same;
         else if (|cas_oth)     win_vec = arb_oth;
         else if (|act_req_arr) win_vec = arb_act;
         else if (|pre_req_arr) win_vec = arb_pre;
      end
   end

   assign act_gnt_arr = win_vec & act_req_arr;
   assign rd_gnt_arr  = win_vec & rd_req_arr;
   assign wr_gnt_arr  = win_vec & wr_req_arr;
   assign pre_gnt_arr = win_vec & pre_req_arr;
   assign ref_gnt_arr = win_vec & ref_req_arr;

   always_comb begin
      win_idx = '0;
      for (int unsigned b = 0; b < BK_CNT; b++) begin
         if (win_vec[b]) win_idx = BA_W'(b);
      end
   end

   always_comb begin
      win_cmd = CMD_NOP;
      if      (|ref_gnt_arr) win_cmd = CMD_REF;
      else if (|rd_gnt_arr)  win_cmd = CMD_RD;
      else if (|wr_gnt_arr)  win_cmd = CMD_WR;
      else if (|act_gnt_arr) win_cmd = CMD_ACT;
      else if (|pre_gnt_arr) win_cmd = CMD_PRE;
   end

   assign ptr_nxt = (win_idx == BA_W'(BK_CNT - 1)) ? '0 : win_idx + 1'b1;

   // Only the pointer of the granted command type advances.
   always_comb begin
      act_ptr_d = act_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      pre_ptr_d = pre_ptr_q;
      ref_ptr_d = ref_ptr_q;
      last_wr_d = last_wr_q;
      case (win_cmd)
         CMD_ACT: act_ptr_d = ptr_nxt;
         CMD_RD:  begin rd_ptr_d = ptr_nxt; last_wr_d = 1'b0; end
         CMD_WR:  begin wr_ptr_d = ptr_nxt; last_wr_d = 1'b1; end
         CMD_PRE: pre_ptr_d = ptr_nxt;
         CMD_REF: ref_ptr_d = ptr_nxt;
         default: ;
      endcase
   end

   // Ages keep counting through stall; a grant or dropped request clears them.
   always_comb begin
      for (int unsigned b = 0; b < BK_CNT; b++) begin
         if (!any_req[b] || win_vec[b])  age_d[b] = '0;
         else if (age_q[b] >= AGE_LIM)   age_d[b] = AGE_LIM;
         else                            age_d[b] = age_q[b] + 1'b1;
      end
   end

   always_comb begin
      cmd_valid_d = |win_vec;
      cmd_d       = win_cmd;
      cmd_ba_d    = '0;
      cmd_ra_d    = '0;
      cmd_ca_d    = '0;
      cmd_id_d    = '0;
      cmd_len_d   = '0;
      if (cmd_valid_d) begin
         cmd_ba_d  = win_idx;
         cmd_ra_d  = ra_arr[win_idx*RA_W +: RA_W];
         cmd_ca_d  = ca_arr[win_idx*CA_W +: CA_W];
         cmd_id_d  = id_arr[win_idx*ID_W +: ID_W];
         cmd_len_d = len_arr[win_idx*LEN_W +: LEN_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_ptr_q   <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         pre_ptr_q   <= '0;
         ref_ptr_q   <= '0;
         last_wr_q   <= 1'b0;
         for (int unsigned b = 0; b < BK_CNT; b++) age_q[b] <= '0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= CMD_NOP;
         cmd_ba_q    <= '0;
         cmd_ra_q    <= '0;
         cmd_ca_q    <= '0;
         cmd_id_q    <= '0;
         cmd_len_q   <= '0;
      end else begin
         act_ptr_q   <= act_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         pre_ptr_q   <= pre_ptr_d;
         ref_ptr_q   <= ref_ptr_d;
         last_wr_q   <= last_wr_d;
         for (int unsigned b = 0; b < BK_CNT; b++) age_q[b] <= age_d[b];
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         cmd_ba_q    <= cmd_ba_d;
         cmd_ra_q    <= cmd_ra_d;
         cmd_ca_q    <= cmd_ca_d;
         cmd_id_q    <= cmd_id_d;
         cmd_len_q   <= cmd_len_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd       = cmd_q;
   assign cmd_ba    = cmd_ba_q;
   assign cmd_ra    = cmd_ra_q;
   assign cmd_ca    = cmd_ca_q;
   assign cmd_id    = cmd_id_q;
   assign cmd_len   = cmd_len_q;

endmodule : sal_sched_rr
`default_nettype wire

// File: tb/tb_sal_sched_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sal_sched_rr                                            |
// | Description : Self-checking bench for sal_sched_rr. Two schedulers       |
// |               (round-robin and fixed priority) share one stimulus; both  |
// |               are compared against a queue-level reference model, plus   |
// |               table vectors and hand-written corner sequences.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sal_sched_rr;
   import sal_sched_pkg::*;

   localparam int BK = 8, RW = 14, CW = 10, IW = 4, LW = 4, LIM = 4;

   logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
   logic [BK-1:0] act_r, rd_r, wr_r, pre_r, ref_r;
   logic [BK*RW-1:0] ra = '0;
   logic [BK*CW-1:0] ca = '0;
   logic [BK*IW-1:0] id = '0;
   logic [BK*LW-1:0] len = '0;
   logic [1:0][BK-1:0] act_g, rd_g, wr_g, pre_g, ref_g;
   logic [1:0] cv;
   logic [1:0][2:0] cmdv, bav;
   logic [1:0][RW-1:0] rav;
   logic [1:0][CW-1:0] cav;
   logic [1:0][IW-1:0] idv;
   logic [1:0][LW-1:0] lenv;

   int btype [BK];          // per bank: 0 idle, else pending sal_cmd_t code
   int n_chk = 0, n_fail = 0;

   // Model state, per instance (0: POLICY=1, 1: POLICY=0).
   int m_age [2][BK];
   int m_ptr [2][6];        // indexed by command code
   int m_dir [2];           // CMD_RD or CMD_WR code
   logic [38:0] e_regs [2];
   int pol [2] = '{1, 0};

   always #5 clk = ~clk;

   always_comb begin
      act_r = '0; rd_r = '0; wr_r = '0; pre_r = '0; ref_r = '0;
      for (int b = 0; b < BK; b++) begin
         act_r[b] = (btype[b] == 1);
         rd_r[b]  = (btype[b] == 2);
         wr_r[b]  = (btype[b] == 3);
         pre_r[b] = (btype[b] == 4);
         ref_r[b] = (btype[b] == 5);
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_dut
      sal_sched_rr #(.BK_CNT(BK), .RA_W(RW), .CA_W(CW), .ID_W(IW), .LEN_W(LW),
                     .POLICY(1 - k), .STARVE_LIM(LIM)) u_dut (
         .clk(clk), .rst(rst), .stall(stall),
         .act_req_arr(act_r), .rd_req_arr(rd_r), .wr_req_arr(wr_r),
         .pre_req_arr(pre_r), .ref_req_arr(ref_r),
         .ra_arr(ra), .ca_arr(ca), .id_arr(id), .len_arr(len),
         .act_gnt_arr(act_g[k]), .rd_gnt_arr(rd_g[k]), .wr_gnt_arr(wr_g[k]),
         .pre_gnt_arr(pre_g[k]), .ref_gnt_arr(ref_g[k]),
         .cmd_valid(cv[k]), .cmd(cmdv[k]), .cmd_ba(bav[k]),
         .cmd_ra(rav[k]), .cmd_ca(cav[k]), .cmd_id(idv[k]), .cmd_len(lenv[k]));
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   function automatic logic [39:0] gvec(input int k);
      return {ref_g[k], pre_g[k], wr_g[k], rd_g[k], act_g[k]};
   endfunction

   function automatic logic [39:0] expvec(input int b, input int t);
      logic [39:0] v = '0;
      if (b >= 0) v[(t - 1) * BK + b] = 1'b1;
      return v;
   endfunction

   function automatic logic [RW-1:0] fra(input int b);
      if (b < 0) return '0;
      return ra[b*RW +: RW];
   endfunction

   // First bank holding request type t, scanning from the class pointer.
   function automatic int m_first(input int k, input int t);
      int s = (pol[k] != 0) ? m_ptr[k][t] : 0;
      for (int i = 0; i < BK; i++) begin
         if (btype[(s + i) % BK] == t) return (s + i) % BK;
      end
      return -1;
   endfunction

   function automatic int m_pick(input int k);
      int b;
      if (rst || stall) return -1;
      b = m_first(k, 5);
      if (b >= 0) return b;
      for (int i = 0; i < BK; i++)
         if (btype[i] != 0 && m_age[k][i] >= LIM) return i;
      b = m_first(k, m_dir[k]);
      if (b >= 0) return b;
      b = m_first(k, 5 - m_dir[k]);
      if (b >= 0) return b;
      b = m_first(k, 1);
      if (b >= 0) return b;
      return m_first(k, 4);
   endfunction

   function automatic void m_update(input int k, input int gb);
      int t;
      if (rst) begin
         for (int i = 0; i < BK; i++) m_age[k][i] = 0;
         for (int i = 0; i < 6; i++) m_ptr[k][i] = 0;
         m_dir[k]  = 2;
         e_regs[k] = '0;
         return;
      end
      e_regs[k] = '0;
      for (int i = 0; i < BK; i++) begin
         if (btype[i] != 0 && i != gb) m_age[k][i] = (m_age[k][i] + 1 > LIM) ? LIM : m_age[k][i] + 1;
         else                          m_age[k][i] = 0;
      end
      if (gb >= 0) begin
         t = btype[gb];
         e_regs[k] = {1'b1, 3'(t), 3'(gb), ra[gb*RW +: RW], ca[gb*CW +: CW],
                      id[gb*IW +: IW], len[gb*LW +: LW]};
         m_ptr[k][t] = (gb + 1) % BK;
         if (t == 2 || t == 3) m_dir[k] = t;
      end
   endfunction

   // One clock: check grants against model (and optional hand value for
   // instance ek), clock, then check the registered command.
   task automatic tick(input int ek, input int eb, input int et, output int g0);
      int gb [2];
      #1;
      for (int k = 0; k < 2; k++) begin
         gb[k] = m_pick(k);
         chk($sformatf("gnt_model%0d", k), 64'(gvec(k)),
             64'(expvec(gb[k], (gb[k] >= 0) ? btype[(gb[k] >= 0) ? gb[k] : 0] : 0)));
      end
      if (eb != -2) chk("hand_gnt", 64'(gvec(ek)), 64'(expvec(eb, et)));
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         m_update(k, gb[k]);
         chk($sformatf("cmd_model%0d", k),
             64'({cv[k], cmdv[k], bav[k], rav[k], cav[k], idv[k], lenv[k]}), 64'(e_regs[k]));
      end
      if (eb != -2)
         chk("hand_cmd", 64'({cv[ek], cmdv[ek], bav[ek], rav[ek]}),
             64'({(eb >= 0), 3'(et), 3'((eb < 0) ? 0 : eb), fra(eb)}));
      g0 = gb[0];
   endtask

   task automatic clear_all();
      for (int b = 0; b < BK; b++) btype[b] = 0;
   endtask

   task automatic do_reset();
      int g;
      rst = 1'b1; stall = 1'b0;
      clear_all();
      tick(0, -1, 0, g);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [7:0] a, r, w, p, f;
      logic       st;
      int         eb, et;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int g;
      for (int b = 0; b < BK; b++) begin
         btype[b] = 0;
         ra[b*RW +: RW] = RW'(b * 3 + 1);
         ca[b*CW +: CW] = CW'(b * 5 + 2);
         id[b*IW +: IW] = IW'(b + 1);
         len[b*LW +: LW] = LW'(15 - b);
      end

      // From reset state: pointers 0, last_dir RD, ages 0.
      tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, -1, 0};
      tbl[1] = '{8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,  2, 1};
      tbl[2] = '{8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 1'b0,  4, 2};
      tbl[3] = '{8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 1'b0,  1, 3};
      tbl[4] = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0,  0, 1};
      tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0,  7, 4};
      tbl[6] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 1'b0,  6, 5};
      tbl[7] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, -1, 0};
      tbl[8] = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 1'b0,  1, 3};
      tbl[9] = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h00, 1'b0,  2, 2};
      for (int v = 0; v < 10; v++) begin
         do_reset();
         for (int b = 0; b < BK; b++)
            btype[b] = tbl[v].f[b] ? 5 : tbl[v].p[b] ? 4 : tbl[v].w[b] ? 3 :
                       tbl[v].r[b] ? 2 : tbl[v].a[b] ? 1 : 0;
         stall = tbl[v].st;
         tick(0, tbl[v].eb, tbl[v].et, g);
         stall = 1'b0;
      end

      // Reset with every bank requesting REF: silent during reset, then bank 0.
      rst = 1'b1;
      for (int b = 0; b < BK; b++) btype[b] = 5;
      tick(0, -1, 0, g);
      tick(0, -1, 0, g);
      rst = 1'b0;
      tick(0, 0, 5, g);
      clear_all();

      // Round-robin ACT sweep, then pointer wrap back to bank 0.
      do_reset();
      for (int b = 0; b < BK; b++) btype[b] = 1;
      for (int i = 0; i < BK; i++) begin
         tick(0, i, 1, g);
         btype[i] = 0;
      end
      btype[3] = 1; btype[0] = 1;
      tick(0, 0, 1, g);
      clear_all();

      // Direction affinity: after a WR, pending WR beats pending RD.
      do_reset();
      btype[5] = 3;
      tick(0, 5, 3, g);
      btype[2] = 2;
      tick(0, 5, 3, g);
      btype[5] = 0;
      tick(0, 2, 2, g);
      clear_all();

      // Starvation: PRE b3 against continuous RD on b0/b1.
      do_reset();
      btype[0] = 2; btype[1] = 2; btype[3] = 4;
      tick(0, 0, 2, g);
      tick(0, 1, 2, g);
      tick(0, 0, 2, g);
      tick(0, 1, 2, g);
      tick(0, 3, 4, g);
      tick(0, 0, 2, g);       // b3 re-requests with a fresh age
      clear_all();

      // Stall holds off an ACT, which issues once stall drops.
      do_reset();
      btype[1] = 1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) tick(0, -1, 0, g);
      stall = 1'b0;
      tick(0, 1, 1, g);
      clear_all();

      // Fixed priority: b4 keeps winning until it drops.
      do_reset();
      btype[4] = 2; btype[6] = 2;
      tick(1, 4, 2, g);
      tick(1, 4, 2, g);
      btype[4] = 0;
      tick(1, 6, 2, g);
      clear_all();

      // Randomised traffic; banks obey instance 0 grants.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         stall = ($urandom_range(0, 9) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         for (int b = 0; b < BK; b++) begin
            ra[b*RW +: RW]  = RW'($urandom);
            ca[b*CW +: CW]  = CW'($urandom);
            id[b*IW +: IW]  = IW'($urandom);
            len[b*LW +: LW] = LW'($urandom);
         end
         tick(0, -2, 0, g);
         for (int b = 0; b < BK; b++) begin
            if (b == g || btype[b] == 0)
               btype[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            else if ($urandom_range(0, 19) == 0)
               btype[b] = 0;
         end
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_sal_sched_rr
`default_nettype wire
